// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size codes, FSM state enum, captured request
// record and the store lane/mask helpers.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [1:0]  boff;
    logic        we;
    logic [2:0]  f3;
    logic [3:0]  bmask;
    logic [31:0] wdata;
  } lsu_req_t;

  // Only the low two funct3 bits pick the size; 011/110/111 fall into word.
  function automatic lsu_size_e lsu_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] a, input logic [2:0] f3);
    lsu_size_e sz;
    sz = lsu_size(f3);
    return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
  endfunction

  function automatic lsu_req_t lsu_pack_req(input logic [31:0] addr,
                                            input logic [31:0] wd,
                                            input logic        we,
                                            input logic [2:0]  f3);
    lsu_req_t r;
    r.waddr = addr[31:2];
    r.boff  = addr[1:0];
    r.we    = we;
    r.f3    = f3;
    r.bmask = 4'b0000;
    r.wdata = 32'h0;
    if (we) begin
      case (lsu_size(f3))
        SZ_B: begin
          r.bmask = 4'b0001 << addr[1:0];
          r.wdata = {4{wd[7:0]}};
        end
        SZ_H: begin
          r.bmask = 4'b0011 << {addr[1], 1'b0};
          r.wdata = {2{wd[15:0]}};
        end
        default: begin
          r.bmask = 4'b1111;
          r.wdata = wd;
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load-data alignment: picks the addressed byte/halfword out of the raw read
// word and sign- or zero-extends it according to funct3.
module lsu_ld_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        zext;

  assign zext = funct3[2];

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (lsu_size(funct3))
      SZ_B:    data = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    data = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding memory operation, word-aligned bus with
// byte-lane masks. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
//
// state      | meaning
// IDLE       | ready for a new operation
// REQ        | memory request presented, waiting for i_mem_ready
// WAIT_RD    | load accepted, waiting for i_mem_rvalid
// RESP       | one-cycle completion pulse
module lsu
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned
);

  lsu_state_e  state, state_nxt;
  lsu_req_t    req_q;
  logic [31:0] ld_data_q;
  logic [31:0] align_data;
  logic        accept;

  assign accept = (state == ST_IDLE) && i_req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_in;
  logic mis_q;
  assign mis_in = lsu_misaligned(i_addr[1:0], i_funct3);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_nxt = mis_in ? ST_RESP : ST_REQ;
`else
          state_nxt = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (i_mem_ready) state_nxt = req_q.we ? ST_RESP : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (i_mem_rvalid) state_nxt = ST_RESP;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Captured request holds the bus fields stable for the whole REQ phase.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_q     <= '0;
      ld_data_q <= '0;
    end else if (accept) begin
      req_q     <= lsu_pack_req(i_addr, i_wdata, i_we, i_funct3);
      ld_data_q <= '0;
    end else if ((state == ST_WAIT_RD) && i_mem_rvalid) begin
      ld_data_q <= align_data;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     mis_q <= 1'b0;
    else if (accept) mis_q <= mis_in;
  end
  assign o_misaligned = mis_q && (state == ST_RESP);
`else
  assign o_misaligned = 1'b0;
`endif

  lsu_ld_align u_ld_align (
    .rdata  (i_mem_rdata),
    .addr   (req_q.boff),
    .funct3 (req_q.f3),
    .data   (align_data)
  );

  always_comb begin
    o_req_ready = (state == ST_IDLE);
    o_mem_valid = (state == ST_REQ);
    o_rsp_valid = (state == ST_RESP);
    o_mem_addr  = 32'h0;
    o_mem_we    = 1'b0;
    o_mem_bmask = 4'b0000;
    o_mem_wdata = 32'h0;
    if (state == ST_REQ) begin
      o_mem_addr  = {req_q.waddr, 2'b00};
      o_mem_we    = req_q.we;
      o_mem_bmask = req_q.bmask;
      o_mem_wdata = req_q.wdata;
    end
  end

  assign o_ld_data = ld_data_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboarded bench for lsu: directed vectors push expected memory requests and
// responses; a monitor compares whatever the DUT presents on the bus and response.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_bmask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_ld_data;
  logic        o_misaligned;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  bmask;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    int          lat;
    time         acc_t;
  } rsp_t;

  mreq_t req_q[$];
  rsp_t  rsp_q[$];

  always #5 clk = ~clk;

  lsu dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we), .i_funct3(i_funct3),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_bmask(o_mem_bmask),
    .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_rsp_valid(o_rsp_valid), .o_ld_data(o_ld_data), .o_misaligned(o_misaligned)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: bus fields checked every cycle the request is up, response on pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_mem_valid) begin
          if (req_q.size() == 0) begin
            chk("mem_valid_unexpected", {31'h0, o_mem_valid}, 32'h0);
          end else begin
            chk("mem_addr", o_mem_addr, req_q[0].addr);
            chk("mem_we", {31'h0, o_mem_we}, {31'h0, req_q[0].we});
            chk("mem_bmask", {28'h0, o_mem_bmask}, {28'h0, req_q[0].bmask});
            chk("mem_wdata", o_mem_wdata, req_q[0].wdata);
            chk("req_ready_busy", {31'h0, o_req_ready}, 32'h0);
            if (i_mem_ready) void'(req_q.pop_front());
          end
        end
        if (o_rsp_valid) begin
          if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", {31'h0, o_rsp_valid}, 32'h0);
          end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            chk("ld_data", o_ld_data, e.ld);
            chk("misaligned", {31'h0, o_misaligned}, {31'h0, e.mis});
            chk("latency", 32'(int'(($time - e.acc_t + 5) / 10)), 32'(e.lat));
          end
        end
      end
    end
  end

  task automatic do_op(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                       input logic [2:0] f3, input logic [31:0] rdata,
                       input int rdly, input int vdly, input bit hold, input bit mem,
                       input logic [3:0] e_bmask, input logic [31:0] e_wdata,
                       input logic [31:0] e_ld, input logic e_mis);
    int n;
    int lat;
    rsp_t r;
    if (mem) req_q.push_back('{ {addr[31:2], 2'b00}, we, e_bmask, e_wdata });
    lat = !mem ? 1 : (we ? 2 + rdly : 3 + rdly + vdly);
    i_addr = addr; i_wdata = wd; i_we = we; i_funct3 = f3; i_req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", {31'h0, o_req_ready}, 32'h1);
    @(posedge clk);
    r.ld = e_ld; r.mis = e_mis; r.lat = lat; r.acc_t = $time;
    rsp_q.push_back(r);
    #1;
    if (hold) begin
      i_addr = ~addr; i_wdata = ~wd; i_we = ~we;
    end else begin
      i_req_valid = 1'b0;
    end
    if (mem) begin
      repeat (rdly) begin @(posedge clk); #1; end
      i_mem_ready = 1'b1; i_req_valid = 1'b0;
      @(posedge clk); #1;
      i_mem_ready = 1'b0;
      if (!we) begin
        repeat (vdly) begin @(posedge clk); #1; end
        i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
        @(posedge clk); #1;
        i_mem_rvalid = 1'b0; i_mem_rdata = ~rdata;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    chk("rst_ld_data", o_ld_data, 32'h0);
    chk("rst_ctl", {25'h0, o_mem_valid, o_mem_we, o_mem_bmask, o_rsp_valid, o_misaligned}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    //    addr          wdata         we  f3      rdata         rd vd hold mem bmask    mwdata        ld            mis
    do_op(32'h0000_1003, 32'h0000_00A5, 1, 3'b000, 32'h0,        0, 0, 0, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0);
    do_op(32'h0000_2002, 32'h1234_BEEF, 1, 3'b001, 32'h0,        0, 0, 0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0);
    do_op(32'h0000_3004, 32'hDEAD_BEEF, 1, 3'b010, 32'h0,        1, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0);
    do_op(32'h0000_4001, 32'h0000_0077, 1, 3'b000, 32'h0,        0, 0, 0, 1, 4'b0010, 32'h7777_7777, 32'h0,        0);
    do_op(32'h0000_5002, 32'h0,         0, 3'b000, 32'h1280_3456, 0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF_FF80, 0);
    do_op(32'h0000_5002, 32'h0,         0, 3'b100, 32'h1280_3456, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_0080, 0);
    do_op(32'h0000_6002, 32'h0,         0, 3'b001, 32'h8001_7FFF, 0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF_8001, 0);
    do_op(32'h0000_6002, 32'h0,         0, 3'b101, 32'h8001_7FFF, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_8001, 0);
    do_op(32'h0000_7008, 32'h0,         0, 3'b010, 32'hCAFE_F00D, 5, 0, 1, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 0);
    do_op(32'h0000_8000, 32'h0102_0304, 1, 3'b011, 32'h0,        0, 0, 0, 1, 4'b1111, 32'h0102_0304, 32'h0,        0);
    do_op(32'h0000_8004, 32'h0,         0, 3'b111, 32'h89AB_CDEF, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h89AB_CDEF, 0);
    do_op(32'h0000_8003, 32'h0,         0, 3'b000, 32'h1122_7F33, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0000_0011, 0);
    do_op(32'h0000_8000, 32'h0,         0, 3'b001, 32'h0000_F00F, 0, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFF_F00F, 0);
    do_op(32'h0000_8000, 32'h0,         0, 3'b101, 32'hFFFF_1234, 0, 3, 0, 1, 4'b0000, 32'h0,        32'h0000_1234, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_op(32'h0000_9001, 32'h0,         0, 3'b010, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1);
`else
    do_op(32'h0000_9001, 32'h0,         0, 3'b010, 32'h5566_7788, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h5566_7788, 0);
`endif

    // Reset while waiting for read data: transaction dropped, late rvalid ignored.
    req_q.push_back('{ 32'h0000_A000, 1'b0, 4'b0000, 32'h0 });
    i_addr = 32'h0000_A000; i_we = 1'b0; i_funct3 = 3'b010; i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_mem_ready = 1'b1;
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {25'h0, o_mem_valid, o_mem_we, o_mem_bmask, o_rsp_valid, o_misaligned}, 32'h0);
    chk("midrst_ready", {31'h0, o_req_ready}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1 i_mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_op(32'h0000_B000, 32'h0,         0, 3'b010, 32'h0BAD_F00D, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0BAD_F00D, 0);

    repeat (4) @(posedge clk);
    chk("req_q_drained", 32'(req_q.size()), 32'h0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
